// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, bit-timing constants and
// the parity helper used by both uart_rx_os and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_LO     = 7;
    localparam int MID_HI     = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic calc_parity(
        input logic [DATA_BITS-1:0] d,
        input logic                 odd
    );
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Host-side bundle of the oversampling receiver: FIFO head, status
// and the pop / error-clear strobes.
interface uart_rx_os_if
    import uart_pkg::*;
#(
    parameter int CW = 4
);

    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic [CW-1:0]        fifo_count;
    logic                 overrun_err;

    modport master (
        output rd_en,
        output err_clr,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  fifo_count,
        input  overrun_err
    );

    modport slave (
        input  rd_en,
        input  err_clr,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output fifo_count,
        output overrun_err
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count; the head
// word reads as zero while empty.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;
    logic             do_push;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with mid-bit majority vote, parity and
// framing checks, feeding a show-ahead FIFO of flagged bytes.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_os_if.slave  host
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int EW      = DATA_BITS + 2;

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_q;
    logic [DW-1:0]        div_cnt;
    logic [3:0]           tcnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 s_lo;
    logic                 s_mid;
    logic                 p_err;
    logic                 ovr;

    logic                 tick;
    logic                 fall;
    logic                 maj;
    logic                 mid;
    logic                 last;
    logic                 push;
    logic                 p_flag;
    logic [EW-1:0]        entry;
    logic [EW-1:0]        head;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;

    assign tick   = (state != IDLE) && (div_cnt == DW'(DIV - 1));
    assign fall   = rx_q & ~rx_s;
    // third sample is the live line value at the decision tick
    assign maj    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign mid    = tick && (tcnt == 4'(MID_HI));
    assign last   = tick && (tcnt == 4'(OVERSAMPLE - 1));
    assign push   = mid && (state == STOP);
    assign p_flag = (PARITY_EN != 0) && p_err;
    assign entry  = {~maj, p_flag, shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            tcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            s_lo    <= 1'b0;
            s_mid   <= 1'b0;
            p_err   <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
            if (state == IDLE) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt + 4'd1;
            end
            if (tick && tcnt == 4'(MID_LO)) begin
                s_lo <= rx_s;
            end
            if (tick && tcnt == 4'(MID_LO + 1)) begin
                s_mid <= rx_s;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        bit_idx <= '0;
                        p_err   <= 1'b0;
                    end
                end
                START: begin
                    if (mid && maj) begin
                        state <= IDLE;
                    end else if (last) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                    end
                    if (last) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        p_err <= calc_parity(shreg, PARITY_ODD != 0) ^ maj;
                    end
                    if (last) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
        end else if (push && full && !host.rd_en) begin
            ovr <= 1'b1;
        end else if (host.err_clr) begin
            ovr <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (host.rd_en),
        .din   (entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign host.data_out    = head[DATA_BITS-1:0];
    assign host.parity_err  = head[DATA_BITS];
    assign host.frame_err   = head[DATA_BITS+1];
    assign host.data_valid  = ~empty;
    assign host.fifo_count  = count;
    assign host.overrun_err = ovr;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are modelled from the
// line-level rules and checked by an independent host-side monitor.
module tb_uart_rx_os;

    localparam int DEPTH    = 8;
    localparam int BIT_CLKS = 16;
    localparam int PODD     = 0;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic rx     = 1'b1;
    logic mon_rd = 1'b0;
    logic tb_rd  = 1'b0;
    logic tb_clr = 1'b0;
    logic mon_en = 1'b0;
    logic exp_ovr = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0] exp_q[$];

    uart_rx_os_if #(.CW(4)) bus();

    assign bus.rd_en   = mon_rd | tb_rd;
    assign bus.err_clr = tb_clr;

    uart_rx_os #(
        .CLK_FREQ   (1600000),
        .BAUD       (100000),
        .PARITY_EN  (1),
        .PARITY_ODD (PODD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .host (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // parity bit a correct transmitter would send for d
    function automatic logic good_par(input logic [7:0] d);
        return ((($countones(d) + PODD) % 2) != 0);
    endfunction

    // expected FIFO entry {frame_err, parity_err, data} from the line bits
    function automatic logic [9:0] model(input logic [7:0] d,
                                         input logic pbit,
                                         input logic stop);
        int  ones;
        logic perr;
        ones = $countones(d) + int'(pbit);
        perr = (((ones + PODD) % 2) != 0);
        return {~stop, perr, d};
    endfunction

    task automatic send_raw(input logic [10:0] bits, input int nclk);
        for (int i = 0; i < nclk; i++) begin
            rx = bits[i / BIT_CLKS];
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pbit,
                        input logic stop, input int gap);
        logic [9:0] e;
        e = model(d, pbit, stop);
        if (exp_q.size() >= DEPTH) begin
            exp_ovr = 1'b1;
        end else begin
            exp_q.push_back(e);
        end
        send_raw({stop, pbit, d, 1'b0}, 11 * BIT_CLKS);
        rx = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !bus.data_valid) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (mon_rd) begin
            mon_rd = 1'b0;
        end else if (mon_en && bus.data_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rx_unexpected: got %0h, expected no entry",
                         {bus.frame_err, bus.parity_err, bus.data_out});
            end else begin
                e = exp_q.pop_front();
                check("rx_entry",
                      {bus.frame_err, bus.parity_err, bus.data_out}, e);
            end
            mon_rd = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] e;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_valid", bus.data_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_perr", bus.parity_err, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_ovr", bus.overrun_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, good_par(8'hA5), 1'b1, 8);
        @(negedge clk);
        check("a5_count", bus.fifo_count, 1);
        check("a5_valid", bus.data_valid, 1);
        e = exp_q.pop_front();
        check("a5_entry", {bus.frame_err, bus.parity_err, bus.data_out}, e);
        tb_rd = 1'b1;
        @(negedge clk);
        tb_rd = 1'b0;
        check("a5_pop_valid", bus.data_valid, 0);
        check("a5_pop_data", bus.data_out, 0);

        mon_en = 1'b1;
        send(8'h3C, ~good_par(8'h3C), 1'b1, 8);
        send(8'h81, good_par(8'h81), 1'b0, 8);
        send(8'h55, good_par(8'h55), 1'b1, 8);
        wait_drain("err_drain");

        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_count", bus.fifo_count, 0);
        check("glitch_valid", bus.data_valid, 0);
        send(8'h12, good_par(8'h12), 1'b1, 8);
        wait_drain("glitch_drain");

        mon_en = 1'b0;
        exp_ovr = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            d = 8'(i);
            send(d, good_par(d), 1'b1, 4);
        end
        @(negedge clk);
        check("ovf_count", bus.fifo_count, exp_q.size());
        check("ovf_flag", bus.overrun_err, exp_ovr);
        mon_en = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_empty", bus.fifo_count, 0);
        mon_en = 1'b0;
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovf_clr", bus.overrun_err, exp_ovr);

        send(8'h5A, good_par(8'h5A), 1'b1, 4);
        @(negedge clk);
        check("pre_rst_count", bus.fifo_count, exp_q.size());
        send_raw({1'b1, good_par(8'hF0), 8'hF0, 1'b0}, 5 * BIT_CLKS + 8);
        rx = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", bus.data_valid, 0);
        check("mid_rst_count", bus.fifo_count, exp_q.size());
        check("mid_rst_data", bus.data_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        send(8'hC3, good_par(8'hC3), 1'b1, 8);
        wait_drain("c3_drain");

        for (int i = 0; i < 24; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) != 0), $urandom_range(1, 20));
        end
        wait_drain("rand_drain");
        check("final_ovr", bus.overrun_err, exp_ovr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone UART receiver with 16x oversampling: 2-FF input synchroniser, 3-sample majority vote at mid-bit, optional parity check and stop-bit framing check.
- Received bytes go into a small show-ahead FIFO with per-byte error flags; the host drains it with a pop strobe.
- Receiving end for the team's uart_tx framing (8 data bits, LSB first, optional parity, 1 stop bit).
- Used wherever a link has to tolerate baud mismatch, glitches and bursty host reads.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line baud rate
OVERSAMPLE, 16, ticks per bit (fixed at 16; majority samples taken at ticks 7, 8 and 9)
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity
FIFO_DEPTH, 8, entries (power of 2, at least 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx  in  1  serial line, asynchronous, idles high
rd_en  in  1  pop strobe; ignored when the FIFO is empty
err_clr  in  1  clears the sticky overrun_err
data_out  out  8  head FIFO byte (show-ahead); 0 when empty
data_valid  out  1  FIFO not empty
parity_err  out  1  parity flag of the head entry; 0 when empty
frame_err  out  1  framing flag of the head entry; 0 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held
overrun_err  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all counters and pointers 0, sync flops 1, all outputs 0. Reset may arrive mid-frame; the partial frame is discarded.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1. Produces a 1-cycle tick every DIV clocks. Divider and tick counter reload to 0 on start detection.
- rx passes through 2 flops (rx_s). Majority = at least 2 of the 3 samples taken at ticks 7, 8 and 9 of the bit; the decision is made at tick 9.
- IDLE: a falling edge on rx_s (previous 1, current 0) moves to START. A line held low does not retrigger.
- START: majority 0 -> DATA, bit index 0. Majority 1 (glitch) -> IDLE, nothing pushed.
- DATA: at tick 15 of each bit, advance to the next bit. Bits shift in LSB first. After bit 7 -> PARITY if PARITY_EN, else STOP.
- PARITY: p_err = (XOR of data bits ^ sampled bit ^ PARITY_ODD) != 0. Then -> STOP.
- STOP: at the mid-bit decision, f_err = (majority == 0). Push {f_err, p_err, data} into the FIFO (p_err = 0 if parity is disabled), then -> IDLE in the same cycle so the next start edge can resynchronise.
- A break (all-zero frame, stop bit low) is pushed as 0x00 with frame_err = 1. No further frames start until rx returns high and falls again.
- FIFO: entries are 10 bits. Push and pop are registered. data_valid and the head flags update on the cycle after the push edge.
  - Latency: stop-bit decision -> data_valid high is 1 clock.
- Push while full with no pop: the new entry is dropped and overrun_err is set. The stored entries are unchanged.
- Push and pop in the same cycle while full: both succeed, count stays at FIFO_DEPTH, no overrun.
- Push and pop in the same cycle while empty: the push succeeds, count goes to 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is exact from 0 to FIFO_DEPTH.
- err_clr clears overrun_err. If err_clr and a new overrun happen in the same cycle, the set wins.

Decomposition:
- Shared package uart_pkg holds:
  - state enum IDLE/START/DATA/PARITY/STOP
  - OVERSAMPLE = 16
  - MID_LO = 7, MID_HI = 9
  - DATA_BITS = 8
  - the parity function, shared with uart_tx
- One sub-module: uart_sync_fifo, a parameterised WIDTH/DEPTH show-ahead FIFO with count, full and empty outputs. It is reusable on the TX side later.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=100000, so DIV=1 and one bit lasts 16 clocks. PARITY_EN=1, PARITY_ODD=0, FIFO_DEPTH=8.
- Send 0xA5 with parity 0 and stop 1 -> data_valid=1, data_out=0xA5, parity_err=0, frame_err=0, fifo_count=1; rd_en for 1 clock -> data_valid=0, data_out=0.
- Send 0x3C with parity bit 1 (wrong) -> data_out=0x3C, parity_err=1, frame_err=0.
- Send 0x81 with a correct parity bit and stop bit 0 -> data_out=0x81, frame_err=1; the next frame 0x55 is received clean after rx returns high.
- Low glitch of 4 clocks on an idle line -> no push, fifo_count=0, FSM back in IDLE; a following 0x12 frame is received correctly.
- Send 9 frames 0x01..0x09 without reading -> fifo_count=8, overrun_err=1; reads return 0x01..0x08 in order; err_clr -> overrun_err=0.
- Pull rst low during DATA bit 4 of a frame -> all outputs 0 immediately; after release, 0xC3 is received correctly.
